// File: rtl/alu_seq_n_bits.sv
// -----------------------------------------------------------------------------
// alu_seq_n_bits
//   Registered N-bit ALU with valid/ready handshakes on the operand and the
//   result side. add/sub/logic/shift ops complete in one cycle. With the
//   ALU_MULDIV_EN macro defined, mul/div/mod run on an iterative engine.
//   mul is shift-add and div/mod is restoring division. Each takes N cycles
//   in CALC. Result and flags are registered together and held while the
//   consumer stalls.
//
// Configuration macro: ALU_MULDIV_EN
//   defined   : opcodes 7/8/9 = mul/div/mod, CALC state and engine present.
//   undefined : opcodes 7/8/9 behave like 10-15 (result = a), busy tied 0.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; a, b, control captured on accept
//   a, b [N-1:0]         operands (b is the shift amount for shifts)
//   control [3:0]        opcode
//   out_valid/out_ready  result handshake
//   result [N-1:0]       registered result
//   v, c, n, z           overflow, carry, negative, zero (registered)
//   busy                 high while an iterative op is running
// -----------------------------------------------------------------------------
module alu_seq_n_bits #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         v,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_MOD = 4'd9;
  localparam int         CNT_W  = $clog2(N);
`endif
  localparam logic [N:0] N_VAL  = (N+1)'(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MULDIV_EN
    , S_CALC = 2'd2
`endif
  } state_t;

  state_t state;
  logic   accept;

  assign out_valid = (state == S_DONE);
  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated straight from the live operands.
  // ---------------------------------------------------------------------------
  logic [N-1:0] s_res;
  logic         s_c, s_v;
  logic [N:0]   sum;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    s_res = a;
    s_c   = 1'b0;
    s_v   = 1'b0;
    sum   = '0;
    case (control)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        s_res = sum[N-1:0];
        s_c   = sum[N];
        s_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        // a + ~b + 1. The carry-out is 1 when no borrow occurs.
        sum   = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        s_res = sum[N-1:0];
        s_c   = sum[N];
        s_v   = (a[N-1] == ~b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_LSR: s_res = ({1'b0, b} >= N_VAL) ? '0 : (a >> b);
      OP_LSL: s_res = ({1'b0, b} >= N_VAL) ? '0 : (a << b);
      default: s_res = a;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // ---------------------------------------------------------------------------
  // Iterative engine. The 2N-bit accumulator is used in two ways:
  //   mul: {partial product high half, remaining multiplier bits}
  //   div: {partial remainder, dividend bits shifting into quotient bits}
  // ---------------------------------------------------------------------------
  logic [2*N-1:0] acc, acc_nxt;
  logic [N:0]     part;
  logic [N-1:0]   op_a, op_b;
  logic [3:0]     op;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]   i_res;
  logic           i_c, i_v;
  logic           is_iter;

  assign is_iter = (control == OP_MUL) | (control == OP_DIV) | (control == OP_MOD);
  assign busy    = (state == S_CALC);

  always_comb begin
    acc_nxt = acc;
    part    = '0;
    if (op == OP_MUL) begin
      part    = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, op_a} : '0);
      acc_nxt = {part, acc[N-1:1]};
    end else begin
      // Trial subtract of the shifted remainder. Bit N set means it went negative.
      part = acc[2*N-1:N-1] - {1'b0, op_b};
      if (!part[N]) acc_nxt = {part[N-1:0], acc[N-2:0], 1'b1};
      else          acc_nxt = {acc[2*N-2:0], 1'b0};
    end
  end

  // Final result and flags, taken from the last step's accumulator.
  always_comb begin
    i_res = acc_nxt[N-1:0];
    i_c   = 1'b0;
    i_v   = 1'b0;
    if (op == OP_MUL) begin
      i_c = |acc_nxt[2*N-1:N];
      i_v = |acc_nxt[2*N-1:N];
    end else if (op_b == '0) begin
      i_res = (op == OP_DIV) ? {N{1'b1}} : op_a;
      i_v   = 1'b1;
    end else if (op == OP_MOD) begin
      i_res = acc_nxt[2*N-1:N];
    end
  end
`else
  assign busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and output registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so each
  // register samples pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      v      <= 1'b0;
      c      <= 1'b0;
      n      <= 1'b0;
      z      <= 1'b0;
`ifdef ALU_MULDIV_EN
      acc    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op     <= '0;
      cnt    <= '0;
`endif
    end else begin
`ifdef ALU_MULDIV_EN
      if (accept && is_iter) begin
        state <= S_CALC;
        acc   <= {{N{1'b0}}, (control == OP_MUL) ? b : a};
        op_a  <= a;
        op_b  <= b;
        op    <= control;
        cnt   <= '0;
      end else
`endif
      if (accept) begin
        state  <= S_DONE;
        result <= s_res;
        v      <= s_v;
        c      <= s_c;
        n      <= s_res[N-1];
        z      <= ~|s_res;
      end else begin
        case (state)
          S_DONE: if (out_ready) state <= S_IDLE;
`ifdef ALU_MULDIV_EN
          S_CALC: begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(N-1)) begin
              state  <= S_DONE;
              result <= i_res;
              v      <= i_v;
              c      <= i_c;
              n      <= i_res[N-1];
              z      <= ~|i_res;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_n_bits
//   Self-checking bench for alu_seq_n_bits (N = 4). A transaction-level model
//   tracks the pending operation: its arithmetic result and the number of
//   cycles left before it is presented. A compare process checks the
//   handshake, busy, result and flags every cycle. Directed cases with literal
//   expectations pin the model. Randomised traffic then stresses handshakes
//   and backpressure. Inputs change 1 time unit after the rising edge.
//   Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_seq_n_bits;
  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;
`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   control = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         v, c, n, z;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_seq_n_bits #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .v(v), .c(c), .n(n), .z(z),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Signed view of an N-bit value
  function automatic int sx(input int x);
    return (x >= (1 << (N-1))) ? x - (1 << N) : x;
  endfunction

  function automatic bit sovf(input int s);
    return (s > (1 << (N-1)) - 1) || (s < -(1 << (N-1)));
  endfunction

  // Reference arithmetic: result plus v and c
  task automatic ref_op(input int ra, input int rb, input int op,
                        output int res, output int rv, output int rc);
    int p;
    res = ra; rv = 0; rc = 0;
    case (op)
      0: begin p = ra + rb; res = p & MASK; rc = int'(p > MASK); rv = int'(sovf(sx(ra) + sx(rb))); end
      1: begin res = (ra - rb) & MASK; rc = int'(ra >= rb); rv = int'(sovf(sx(ra) - sx(rb))); end
      2: res = ra & rb;
      3: res = ra | rb;
      4: res = ra ^ rb;
      5: res = (rb >= N) ? 0 : (ra >> rb);
      6: res = (rb >= N) ? 0 : ((ra << rb) & MASK);
      7: if (MULDIV) begin p = ra * rb; res = p & MASK; rc = int'(p > MASK); rv = rc; end
      8: if (MULDIV) begin
           if (rb == 0) begin res = MASK; rv = 1; end else res = ra / rb;
         end
      9: if (MULDIV) begin
           if (rb == 0) begin res = ra; rv = 1; end else res = ra % rb;
         end
      default: res = ra;
    endcase
  endtask

  // Transaction model: one op at most in flight. m_wait counts cycles to output.
  bit m_has = 0;
  int m_wait = 0;
  int m_res = 0, m_v = 0, m_c = 0;
  bit m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_has = 0; m_wait = 0;
    end else begin
      m_acc = in_valid && (!m_has || (m_wait == 0 && out_ready));
      if (m_has && m_wait == 0 && out_ready) m_has = 0;
      else if (m_has && m_wait > 0) m_wait--;
      if (m_acc) begin
        m_has  = 1;
        m_wait = (MULDIV && control inside {4'd7, 4'd8, 4'd9}) ? N : 0;
        ref_op(int'(a), int'(b), int'(control), m_res, m_v, m_c);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(m_has && m_wait == 0));
      check("in_ready",  32'(in_ready),  32'(!m_has || (m_wait == 0 && out_ready)));
      check("busy",      32'(busy),      32'(m_has && m_wait > 0));
      if (m_has && m_wait == 0) begin
        check("result", 32'(result), m_res);
        check("vcnz", 32'({v, c, n, z}),
              32'({m_v[0], m_c[0], m_res[N-1], m_res == 0}));
      end
    end
  end

  // Directed op with literal expectations: latency, result and {v,c,n,z}
  task automatic do_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                       input logic [3:0] op, input int exp_lat,
                       input logic [N-1:0] exp_res, input logic [3:0] exp_vcnz);
    int  lat;
    bit  seen;
    @(posedge clk); #1;
    a = ta; b = tb_v; control = op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, 32'(result), 32'(exp_res));
    check({name, " vcnz"}, 32'({v, c, n, z}), 32'(exp_vcnz));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    #22 rst_n = 1'b1;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset vcnz", 32'({v, c, n, z}), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);

    do_op("add 7+1", 4'b0111, 4'b0001, 4'd0, 1, 4'b1000, 4'b1010);
    do_op("sub 3-3", 4'b0011, 4'b0011, 4'd1, 1, 4'b0000, 4'b0101);
    do_op("sub 0-1", 4'b0000, 4'b0001, 4'd1, 1, 4'b1111, 4'b0010);
    do_op("xor",     4'b1010, 4'b0110, 4'd4, 1, 4'b1100, 4'b0010);
    do_op("lsr 8>>1", 4'b1000, 4'b0001, 4'd5, 1, 4'b0100, 4'b0000);
    do_op("lsl 1<<4", 4'b0001, 4'b0100, 4'd6, 1, 4'b0000, 4'b0001);
    do_op("op12",    4'b0110, 4'b0011, 4'd12, 1, 4'b0110, 4'b0000);
`ifdef ALU_MULDIV_EN
    do_op("mul 5*3", 4'b0101, 4'b0011, 4'd7, 5, 4'b1111, 4'b0010);
    do_op("mul 8*2", 4'b1000, 4'b0010, 4'd7, 5, 4'b0000, 4'b1101);
    do_op("div 13/4", 4'b1101, 4'b0100, 4'd8, 5, 4'b0011, 4'b0000);
    do_op("mod 13%4", 4'b1101, 4'b0100, 4'd9, 5, 4'b0001, 4'b0000);
    do_op("div 6/0", 4'b0110, 4'b0000, 4'd8, 5, 4'b1111, 4'b1010);
    do_op("mod 6%0", 4'b0110, 4'b0000, 4'd9, 5, 4'b0110, 4'b1000);
`else
    do_op("op7 passthru", 4'b0101, 4'b0011, 4'd7, 1, 4'b0101, 4'b0000);
    check("op7 busy", 32'(busy), 32'd0);
`endif

    // Backpressure: add 2+3 held for 3 cycles, then the next op is accepted on the release edge
    @(posedge clk); #1;
    a = 4'd2; b = 4'd3; control = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold result", 32'(result), 32'd5);
      check("hold vcnz", 32'({v, c, n, z}), 32'd0);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    a = 4'b0001; b = 4'b0100; control = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lsl after hold valid", 32'(out_valid), 32'd1);
    check("lsl after hold result", 32'(result), 32'd0);
    check("lsl after hold z", 32'(z), 32'd1);

    // Reset while a result is held: outputs clear at once
    @(posedge clk); #1;
    a = 4'd2; b = 4'd3; control = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", 32'(result), 32'd0);
    #10 rst_n = 1'b1;
    out_ready = 1'b1;
`ifdef ALU_MULDIV_EN
    // Reset two cycles into a multiply: no result is ever presented
    @(posedge clk); #1;
    a = 4'b0101; b = 4'b0011; control = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst mid-mul busy", 32'(busy), 32'd0);
    check("rst mid-mul valid", 32'(out_valid), 32'd0);
    check("rst mid-mul vcnz", 32'({v, c, n, z}), 32'd0);
    #10 rst_n = 1'b1;
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      a         = N'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      control   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drained", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
